// File: rtl/axi_llc_refill_r_slave_pkg.sv
// Shared configuration, enums and default channel types for the LLC refill R slave.
// The concrete LLC top normally overrides the default struct types through type parameters.
package axi_llc_refill_r_slave_pkg;

  typedef struct packed {
    int unsigned NoBlocks;
    int unsigned BlockSize;
    int unsigned BlockOffsetLength;
    int unsigned ByteOffsetLength;
    int unsigned IndexLength;
  } llc_cfg_t;

  typedef struct packed {
    int unsigned SlvPortIdWidth;
    int unsigned MstPortIdWidth;
    int unsigned AddrWidthFull;
    int unsigned DataWidthFull;
  } llc_axi_cfg_t;

  localparam llc_cfg_t DefaultCfg = '{
    NoBlocks:          32'd4,
    BlockSize:         32'd64,
    BlockOffsetLength: 32'd2,
    ByteOffsetLength:  32'd3,
    IndexLength:       32'd8
  };

  localparam llc_axi_cfg_t DefaultAxiCfg = '{
    SlvPortIdWidth: 32'd4,
    MstPortIdWidth: 32'd4,
    AddrWidthFull:  32'd32,
    DataWidthFull:  32'd64
  };

  typedef enum logic [1:0] {
    EvictUnit = 2'd0,
    RefilUnit = 2'd1,
    WChanUnit = 2'd2,
    RChanUnit = 2'd3
  } cache_unit_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    SEND   = 2'd2
  } refill_state_e;

  // ID the LLC puts on its own refill AR requests.
  localparam int unsigned AxReqId = 32'hB;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef struct packed {
    logic [31:0] a_x_addr;
    logic [7:0]  way_ind;
    logic        refill;
  } llc_desc_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } llc_r_chan_t;

  typedef struct packed {
    cache_unit_e cache_unit;
    logic [7:0]  way_ind;
    logic [7:0]  line_addr;
    logic [1:0]  blk_ofs;
    logic        we;
    logic [63:0] data;
    logic [7:0]  strb;
  } llc_way_inp_t;

endpackage

// File: rtl/axi_llc_refill_r_slave_counter.sv
// Beat counter within a cache line: synchronous clear has priority over increment.
module axi_llc_refill_r_slave_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else if (clear_i) begin
      cnt_reg <= '0;
    end else if (en_i) begin
      cnt_reg <= cnt_reg + Width'(1);
    end
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/axi_llc_refill_r_slave.sv
// Drains a refill R burst into the data storage one block per beat, then releases
// the descriptor; non-refill descriptors skip straight to the release state.
module axi_llc_refill_r_slave
  import axi_llc_refill_r_slave_pkg::*;
#(
  parameter llc_cfg_t     Cfg       = DefaultCfg,
  parameter llc_axi_cfg_t AxiCfg    = DefaultAxiCfg,
  parameter type          desc_t    = llc_desc_t,
  parameter type          r_chan_t  = llc_r_chan_t,
  parameter type          way_inp_t = llc_way_inp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  desc_t    desc_i,
  input  logic     desc_valid_i,
  output logic     desc_ready_o,
  output desc_t    desc_o,
  output logic     desc_valid_o,
  input  logic     desc_ready_i,
  output logic     desc_err_o,
  input  r_chan_t  r_chan_mst_i,
  input  logic     r_chan_valid_i,
  output logic     r_chan_ready_o,
  output way_inp_t way_inp_o,
  output logic     way_inp_valid_o,
  input  logic     way_inp_ready_i
);

  localparam int unsigned NoBlocks    = Cfg.NoBlocks;
  localparam int unsigned IndexLength = Cfg.IndexLength;
  localparam int unsigned AddrOffset  = Cfg.BlockOffsetLength + Cfg.ByteOffsetLength;
  localparam int unsigned IdWidth     = AxiCfg.MstPortIdWidth;
  localparam int unsigned CntWidth    = (NoBlocks > 1) ? $clog2(NoBlocks) : 1;
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NoBlocks - 1);

  refill_state_e       state_reg, state_next;
  desc_t               desc_reg;
  logic                err_reg, err_next;
  logic [CntWidth-1:0] beat_cnt;
  logic                desc_accept, beat_fire, cnt_at_last, beat_err;

  assign desc_accept = (state_reg == IDLE) && desc_valid_i;
  assign beat_fire   = (state_reg == REFILL) && r_chan_valid_i && way_inp_ready_i;
  assign cnt_at_last = (beat_cnt == LastCnt);

  // r.last only feeds the error flag; the counter alone decides where the line ends.
  assign beat_err = (r_chan_mst_i.resp inside {RespSlvErr, RespDecErr})
                 || (r_chan_mst_i.last != cnt_at_last)
                 || (r_chan_mst_i.id != IdWidth'(AxReqId));

  axi_llc_refill_r_slave_counter #(
    .Width (CntWidth)
  ) i_beat_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (desc_accept),
    .en_i    (beat_fire),
    .cnt_o   (beat_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (desc_valid_i) begin
          state_next = desc_i.refill ? REFILL : SEND;
        end
      end
      REFILL: begin
        if (beat_fire && cnt_at_last) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (desc_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    err_next = err_reg;
    if (desc_accept) begin
      err_next = 1'b0;
    end else if (beat_fire && beat_err) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      desc_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (desc_accept) begin
        desc_reg <= desc_i;
      end
      err_reg <= err_next;
    end
  end

  always_comb begin
    desc_ready_o    = 1'b0;
    desc_valid_o    = 1'b0;
    r_chan_ready_o  = 1'b0;
    way_inp_valid_o = 1'b0;
    way_inp_o       = '0;
    case (state_reg)
      // Gated with reset so the upstream sees no ready while reset is held.
      IDLE: desc_ready_o = rst_ni;
      REFILL: begin
        way_inp_valid_o      = r_chan_valid_i;
        r_chan_ready_o       = way_inp_ready_i;
        way_inp_o.cache_unit = RefilUnit;
        way_inp_o.way_ind    = desc_reg.way_ind;
        way_inp_o.line_addr  = desc_reg.a_x_addr[AddrOffset +: IndexLength];
        way_inp_o.blk_ofs    = beat_cnt;
        way_inp_o.we         = 1'b1;
        way_inp_o.data       = r_chan_mst_i.data;
        way_inp_o.strb       = '1;
      end
      SEND: desc_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign desc_o     = desc_reg;
  assign desc_err_o = err_reg;

`ifndef SYNTHESIS
  last_matches_counter: assert property (@(posedge clk_i) disable iff (!rst_ni)
    beat_fire |-> (r_chan_mst_i.last == cnt_at_last))
    else $error("refill R beat: last flag disagrees with beat counter");

  way_inp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (way_inp_valid_o && !way_inp_ready_i) |=> $stable(way_inp_o))
    else $error("way write request changed while stalled");
`endif

endmodule

// File: tb/tb_axi_llc_refill_r_slave.sv
// Directed bench for the refill R slave: pass-through, refills, stalls, errors, reset.
module tb_axi_llc_refill_r_slave;
  import axi_llc_refill_r_slave_pkg::*;

  logic         clk = 1'b0;
  logic         rst_ni;
  llc_desc_t    desc_i, desc_o;
  logic         desc_valid_i, desc_ready_o, desc_valid_o, desc_ready_i, desc_err_o;
  llc_r_chan_t  r_beat;
  logic         r_chan_valid_i, r_chan_ready_o;
  llc_way_inp_t way_inp_o;
  logic         way_inp_valid_o, way_inp_ready_i;

  int           checks = 0;
  int           errors = 0;
  int           wr_count = 0;
  logic [1:0]   ofs_log [0:31];
  logic [7:0]   exp_line, exp_way;
  llc_desc_t    d;

  always #5 clk = ~clk;

  axi_llc_refill_r_slave dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .desc_i          (desc_i),
    .desc_valid_i    (desc_valid_i),
    .desc_ready_o    (desc_ready_o),
    .desc_o          (desc_o),
    .desc_valid_o    (desc_valid_o),
    .desc_ready_i    (desc_ready_i),
    .desc_err_o      (desc_err_o),
    .r_chan_mst_i    (r_beat),
    .r_chan_valid_i  (r_chan_valid_i),
    .r_chan_ready_o  (r_chan_ready_o),
    .way_inp_o       (way_inp_o),
    .way_inp_valid_o (way_inp_valid_o),
    .way_inp_ready_i (way_inp_ready_i)
  );

  // Record every data-storage write handshake with its block offset.
  always @(posedge clk) begin
    if (rst_ni && way_inp_valid_o && way_inp_ready_i) begin
      ofs_log[wr_count[4:0]] <= way_inp_o.blk_ofs;
      wr_count <= wr_count + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input llc_desc_t dd);
    desc_i = dd;
    desc_valid_i = 1'b1;
    #1;
    chk("accept_ready", desc_ready_o, 1);
    @(posedge clk); #1;
    desc_valid_i = 1'b0;
    desc_i = '0;
    #1;
    chk("busy_ready", desc_ready_o, 0);
  endtask

  task automatic beat(input logic [1:0] ofs, input logic [63:0] data, input logic [1:0] resp,
                      input logic [3:0] id, input int stall);
    r_beat.id = id;
    r_beat.data = data;
    r_beat.resp = resp;
    r_beat.last = (ofs == 2'd3);
    r_chan_valid_i = 1'b1;
    way_inp_ready_i = 1'b0;
    for (int i = 0; i < stall; i++) begin
      #1;
      chk("stall_rready", r_chan_ready_o, 0);
      chk("stall_wvalid", way_inp_valid_o, 1);
      @(posedge clk); #1;
    end
    way_inp_ready_i = 1'b1;
    #1;
    chk("rready", r_chan_ready_o, 1);
    chk("wvalid", way_inp_valid_o, 1);
    chk("blk_ofs", way_inp_o.blk_ofs, ofs);
    chk("line_addr", way_inp_o.line_addr, exp_line);
    chk("way_ind", way_inp_o.way_ind, exp_way);
    chk("wdata", way_inp_o.data, data);
    chk("unit", way_inp_o.cache_unit, RefilUnit);
    chk("we_strb", {way_inp_o.we, way_inp_o.strb}, 9'h1FF);
    @(posedge clk); #1;
    r_chan_valid_i = 1'b0;
    way_inp_ready_i = 1'b0;
  endtask

  task automatic finish_send(input llc_desc_t dd, input logic err);
    #1;
    chk("send_valid", desc_valid_o, 1);
    chk("send_err", desc_err_o, err);
    chk("send_desc", desc_o, dd);
    chk("send_rready", r_chan_ready_o, 0);
    desc_ready_i = 1'b1;
    @(posedge clk); #1;
    desc_ready_i = 1'b0;
    #1;
    chk("idle_valid", desc_valid_o, 0);
    chk("idle_ready", desc_ready_o, 1);
  endtask

  initial begin
    rst_ni = 1'b0;
    desc_i = '0;
    desc_valid_i = 1'b0;
    desc_ready_i = 1'b0;
    r_beat = '0;
    r_chan_valid_i = 1'b0;
    way_inp_ready_i = 1'b0;
    exp_line = 8'h00;
    exp_way = 8'h00;
    #2;
    chk("rst_desc_ready", desc_ready_o, 0);
    chk("rst_desc_valid", desc_valid_o, 0);
    chk("rst_rready", r_chan_ready_o, 0);
    chk("rst_wvalid", way_inp_valid_o, 0);
    chk("rst_err", desc_err_o, 0);
    chk("rst_desc_o", desc_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    #1;
    chk("post_rst_ready", desc_ready_o, 1);
    chk("post_rst_valid", desc_valid_o, 0);

    // Non-refill descriptor passes through one cycle after acceptance.
    d = '{a_x_addr: 32'h1234_5678, way_ind: 8'h01, refill: 1'b0};
    accept(d);
    finish_send(d, 1'b0);

    // Plain refill: index 0x12, way 0b0100, data A0..A3.
    exp_line = 8'h12; exp_way = 8'h04;
    d = '{a_x_addr: 32'hABC0_0240, way_ind: 8'h04, refill: 1'b1};
    accept(d);
    beat(2'd0, 64'hA0, RespOkay, 4'hB, 0);
    beat(2'd1, 64'hA1, RespOkay, 4'hB, 0);
    beat(2'd2, 64'hA2, RespOkay, 4'hB, 0);
    beat(2'd3, 64'hA3, RespOkay, 4'hB, 0);
    finish_send(d, 1'b0);
    chk("wr_count_1", wr_count, 4);
    chk("ofs_seq_1", {ofs_log[0], ofs_log[1], ofs_log[2], ofs_log[3]}, 8'h1B);

    // SLVERR on beat 1, storage stalls beat 2 for 3 cycles.
    exp_line = 8'h3C; exp_way = 8'h80;
    d = '{a_x_addr: 32'h0000_0780, way_ind: 8'h80, refill: 1'b1};
    accept(d);
    beat(2'd0, 64'hB0, RespOkay, 4'hB, 0);
    beat(2'd1, 64'hB1, RespSlvErr, 4'hB, 0);
    beat(2'd2, 64'hB2, RespOkay, 4'hB, 3);
    beat(2'd3, 64'hB3, RespOkay, 4'hB, 0);
    finish_send(d, 1'b1);
    chk("wr_count_2", wr_count, 8);
    chk("ofs_seq_2", {ofs_log[4], ofs_log[5], ofs_log[6], ofs_log[7]}, 8'h1B);

    // Clean refill after an erroneous one; SEND held 5 cycles with R pending.
    exp_line = 8'hFF; exp_way = 8'h01;
    d = '{a_x_addr: 32'h0000_1FE0, way_ind: 8'h01, refill: 1'b1};
    accept(d);
    beat(2'd0, 64'hC0, RespOkay, 4'hB, 0);
    beat(2'd1, 64'hC1, RespOkay, 4'hB, 0);
    beat(2'd2, 64'hC2, RespOkay, 4'hB, 0);
    beat(2'd3, 64'hC3, RespOkay, 4'hB, 0);
    r_beat.data = 64'hDEAD;
    r_beat.last = 1'b0;
    r_chan_valid_i = 1'b1;
    way_inp_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_valid", desc_valid_o, 1);
      chk("hold_desc", desc_o, d);
      chk("hold_ready", desc_ready_o, 0);
      chk("hold_rready", r_chan_ready_o, 0);
      chk("hold_wvalid", way_inp_valid_o, 0);
      @(posedge clk);
    end
    #1;
    r_chan_valid_i = 1'b0;
    way_inp_ready_i = 1'b0;
    finish_send(d, 1'b0);
    chk("wr_count_3", wr_count, 12);

    // Reset pulsed after beat 2 of 4.
    exp_line = 8'h12; exp_way = 8'h04;
    d = '{a_x_addr: 32'hABC0_0240, way_ind: 8'h04, refill: 1'b1};
    accept(d);
    beat(2'd0, 64'hD0, RespOkay, 4'hB, 0);
    beat(2'd1, 64'hD1, RespSlvErr, 4'hB, 0);
    rst_ni = 1'b0;
    r_beat.data = 64'hD2;
    r_chan_valid_i = 1'b1;
    way_inp_ready_i = 1'b1;
    #1;
    chk("mid_rst_ready", desc_ready_o, 0);
    chk("mid_rst_rready", r_chan_ready_o, 0);
    chk("mid_rst_wvalid", way_inp_valid_o, 0);
    chk("mid_rst_dvalid", desc_valid_o, 0);
    chk("mid_rst_err", desc_err_o, 0);
    chk("mid_rst_desc", desc_o, 0);
    chk("mid_rst_way_inp", way_inp_o, 0);
    repeat (2) @(posedge clk);
    #1;
    r_chan_valid_i = 1'b0;
    way_inp_ready_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    chk("after_rst_ready", desc_ready_o, 1);
    chk("wr_count_rst", wr_count, 14);

    // Fresh refill restarts at block 0; a foreign ID on the last beat flags an error.
    accept(d);
    beat(2'd0, 64'hE0, RespOkay, 4'hB, 0);
    beat(2'd1, 64'hE1, RespOkay, 4'hB, 0);
    beat(2'd2, 64'hE2, RespOkay, 4'hB, 0);
    beat(2'd3, 64'hE3, RespOkay, 4'h3, 0);
    finish_send(d, 1'b1);
    chk("wr_count_5", wr_count, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_llc_refill_r_slave.md
# axi_llc_refill_r_slave

Receiving end of the refill path in the AXI LLC. It consumes descriptors from the refill AR master and drains the matching AXI R burst from the memory-side master port. Each beat is written into the data storage as a way write request, and the descriptor is released downstream once the whole cache line has been written. Descriptors without the refill flag pass straight through without touching the R channel.

## Interface
- Cfg, -1, axi_llc_pkg::llc_cfg_t; uses NoBlocks, BlockSize, BlockOffsetLength, ByteOffsetLength, IndexLength.
- AxiCfg, -1, axi_llc_pkg::llc_axi_cfg_t; uses MstPortIdWidth.
- desc_t, logic, LLC descriptor; fields used: refill, way_ind, a_x_addr.
- r_chan_t, logic, AXI R channel struct of the master port.
- way_inp_t, logic, data-storage write request: cache_unit, way_ind, line_addr, blk_ofs, we, data, strb.
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous reset, active low.
- desc_i  input  desc_t  descriptor from the refill AR master.
- desc_valid_i  input  1  descriptor valid.
- desc_ready_o  output  1  descriptor ready.
- desc_o  output  desc_t  descriptor forwarded downstream.
- desc_valid_o  output  1  forwarded descriptor valid.
- desc_ready_i  input  1  downstream ready.
- desc_err_o  output  1  error flag for the refill; meaningful only while desc_valid_o is high.
- r_chan_mst_i  input  r_chan_t  R beat.
- r_chan_valid_i  input  1  R valid.
- r_chan_ready_o  output  1  R ready.
- way_inp_o  output  way_inp_t  data-storage write request.
- way_inp_valid_o  output  1  write request valid.
- way_inp_ready_i  input  1  data storage ready.

## Operation
- FSM states: IDLE, REFILL, SEND. Reset state is IDLE.
- IDLE:
  - desc_ready_o = 1.
  - On desc_valid_i: register desc_i, clear the beat counter, clear the error flag.
  - Next state is REFILL if desc_i.refill is set, otherwise SEND.
- REFILL:
  - way_inp_valid_o = r_chan_valid_i.
  - r_chan_ready_o = way_inp_ready_i.
  - A beat is consumed only when r_chan_valid_i and way_inp_ready_i are both high.
- way_inp_o fields:
  - cache_unit = RefilUnit, we = 1, strb = all ones.
  - way_ind = desc_q.way_ind.
  - line_addr = desc_q.a_x_addr[AddrOffset +: IndexLength], with AddrOffset = BlockOffsetLength + ByteOffsetLength.
  - blk_ofs = beat counter.
  - data = r.data.
- Beat counter:
  - Width is max(1, $clog2(NoBlocks)).
  - Increments on each consumed beat.
  - The consumed beat with counter == NoBlocks-1 is the last beat; on it, transition to SEND.
  - The counter alone defines burst end; r.last is checked only.
- Error flag (sticky per descriptor), set by any of:
  - a consumed beat with r.resp of SLVERR or DECERR;
  - r.last disagreeing with the counter;
  - r.id != axi_llc_pkg::AxReqId.
- SEND:
  - desc_valid_o = 1, desc_o = desc_q, desc_err_o = error flag.
  - On desc_ready_i, return to IDLE.
- Outside their states, r_chan_ready_o, way_inp_valid_o and desc_valid_o are 0.
- way_inp_o and desc_o are don't-care while their valid is low.
- NoBlocks = 1: the first beat is the last beat.

## Timing
- Reset values: desc_ready_o = 0 during reset and 1 after reset (IDLE). All other outputs, including desc_err_o and the registered descriptor, are 0.
- R to way_inp is combinational: zero-cycle latency. way_inp_valid_o must not depend on r_chan_ready_o.
- Non-refill descriptor: desc_valid_o is asserted 1 cycle after the input handshake.
- Refill descriptor: desc_valid_o is asserted the cycle after the last beat handshake.
- Minimum occupancy is NoBlocks + 2 cycles per refill descriptor. desc_ready_o is low from acceptance until the SEND handshake completes.
- Backpressure:
  - way_inp_ready_i low → r_chan_ready_o low, and the beat is held by the AXI slave.
  - desc_ready_i low → SEND is held indefinitely with desc_o stable, and no new R beats are accepted.
- Valid must never drop without the corresponding ready (AXI rule on all outputs).
- Reset asserted mid-refill: immediate return to IDLE with counter and flags cleared. The partially written line is not invalidated here; the upstream reset covers the tag storage.

## Structure
- axi_llc_pkg provides cache_unit_e (RefilUnit) and AxReqId; the block adds nothing to it.
- desc_t, r_chan_t and way_inp_t are defined at the LLC top and passed as type parameters.
- Registers use the FFARN/FFLARN macros from common_cells/registers.svh.
- The beat counter is the common_cells counter sub-module, with width max(1, $clog2(NoBlocks)) and clear on descriptor accept.
- Simulation-only assertions:
  - r.last == (counter == NoBlocks-1) on each consumed beat;
  - stability of way_inp_o while valid and not ready.

## Test plan
- Non-refill pass-through: desc with refill=0 accepted at cycle 0 → desc_valid_o=1 at cycle 1, desc_err_o=0, r_chan_ready_o stays 0.
- Full refill, NoBlocks=4, index 0x12, way_ind=0b0100, data A0..A3 → four way_inp handshakes with blk_ofs 0,1,2,3 and line_addr 0x12, then desc_valid_o one cycle after beat 3.
- way_inp_ready_i low for 3 cycles on beat 2 → r_chan_ready_o low for those 3 cycles, beat 2 written exactly once, blk_ofs sequence unchanged.
- resp=SLVERR on beat 1 → desc_err_o=1 in SEND; the following refill with all OKAY beats → desc_err_o=0.
- desc_ready_i low for 5 cycles in SEND, R valid pending → desc_o stable, desc_ready_o=0, r_chan_ready_o=0 throughout; accepted on the 6th cycle.
- rst_ni pulsed low after beat 2 of 4 → all outputs 0 during reset, IDLE afterwards; a new refill then writes blk_ofs starting from 0.
